// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST master: FSM states and the LFSR polynomial.
// LFSR is a right-shifting Galois form with feedback taps x^32+x^22+x^2+x+1.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_TURN = 3'd2,
        ST_RD   = 3'd3,
        ST_DONE = 3'd4
    } bist_state_t;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/mem_bist_lfsr.sv
// 32-bit Galois LFSR pattern source; load has priority over step, pattern is the low WIDTH bits.
// Output is registered state; no backpressure of its own (step is driven by the handshake).
module mem_bist_lfsr
    import mem_bist_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter logic [31:0] SEED  = DEFAULT_SEED
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [31:0]      i_seed,
    output logic [WIDTH-1:0] o_pattern
);

    logic [31:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_step) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_pattern = r_lfsr[WIDTH-1:0];

endmodule

// File: rtl/mem_bist_master.sv
// Memory BIST initiator: write LFSR pattern over a wrapping address range, read back and compare.
// Holds requests while ready is low (bounded by TIMEOUT); MEM_BIST_FIRST_ERR_EN adds first-error capture.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          ADDR_WIDTH = 6,
    parameter int          DEPTH      = 64,
    parameter logic [31:0] SEED       = DEFAULT_SEED,
    parameter int          TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_num_loc,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [ADDR_WIDTH:0]   o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr,
    output logic [WIDTH-1:0]      o_first_err_data,
    output logic                  o_valid,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [WIDTH-1:0]      o_wdata,
    input  logic [WIDTH-1:0]      i_rdata,
    input  logic                  i_ready
);

    localparam int                  WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] ERR_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};

    bist_state_t           r_state;
    logic                  r_busy, r_done, r_timeout, r_valid, r_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr, r_base, r_num, r_cnt;
    logic [WAIT_W-1:0]     r_wait;
    logic [ADDR_WIDTH:0]   r_err_count;
    logic                  r_cmp_vld;
    logic [WIDTH-1:0]      r_cmp_data, r_cmp_exp;

    logic                  w_hs, w_start_ok, w_mismatch, w_lfsr_load;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [WIDTH-1:0]      w_pattern;

    assign w_hs        = r_valid && i_ready;
    assign w_start_ok  = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_mismatch  = r_cmp_vld && (r_cmp_data != r_cmp_exp);
    assign w_lfsr_load = w_start_ok || (r_state == ST_TURN);
    assign w_addr_next = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + 1'b1;

    mem_bist_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_lfsr_load),
        .i_step    (w_hs),
        .i_seed    (SEED),
        .o_pattern (w_pattern)
    );

    // Compare runs one cycle after the read handshake off registered rdata, so the read
    // phase ends with a single drain cycle (valid low, still busy) before DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_valid     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_base      <= '0;
            r_num       <= '0;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_err_count <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_data  <= '0;
            r_cmp_exp   <= '0;
        end else begin
            r_cmp_vld <= 1'b0;
            if (w_mismatch && r_err_count != ERR_MAX) begin
                r_err_count <= r_err_count + 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state     <= ST_WR;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_valid     <= 1'b1;
                        r_wr_en     <= 1'b1;
                        r_addr      <= i_start_addr;
                        r_base      <= i_start_addr;
                        r_num       <= i_num_loc;
                        r_cnt       <= i_num_loc;
                        r_wait      <= '0;
                        r_err_count <= '0;
                    end
                end
                ST_TURN: begin
                    r_state <= ST_RD;
                    r_valid <= 1'b1;
                    r_addr  <= r_base;
                    r_cnt   <= r_num;
                    r_wait  <= '0;
                end
                default: begin
                    if (!r_valid) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (i_ready) begin
                        r_wait <= '0;
                        r_addr <= w_addr_next;
                        if (r_state == ST_RD) begin
                            r_cmp_vld  <= 1'b1;
                            r_cmp_data <= i_rdata;
                            r_cmp_exp  <= w_pattern;
                        end
                        if (r_cnt == '0) begin
                            r_valid <= 1'b0;
                            r_wr_en <= 1'b0;
                            if (r_state == ST_WR) begin
                                r_state <= ST_TURN;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b0;
                        r_wr_en   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef MEM_BIST_FIRST_ERR_EN
    logic [ADDR_WIDTH-1:0] r_cmp_addr, r_first_err_addr;
    logic [WIDTH-1:0]      r_first_err_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmp_addr       <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
        end else begin
            if (w_start_ok) begin
                r_first_err_addr <= '0;
                r_first_err_data <= '0;
            end else if (w_mismatch && r_err_count == '0) begin
                r_first_err_addr <= r_cmp_addr;
                r_first_err_data <= r_cmp_data;
            end
            if (w_hs && r_state == ST_RD) begin
                r_cmp_addr <= r_addr;
            end
        end
    end

    assign o_first_err_addr = r_first_err_addr;
    assign o_first_err_data = r_first_err_data;
`else
    assign o_first_err_addr = '0;
    assign o_first_err_data = '0;
`endif

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_timeout   = r_timeout;
    assign o_err_count = r_err_count;
    assign o_pass      = r_done && (r_err_count == '0) && !r_timeout;
    assign o_valid     = r_valid;
    assign o_wr_en     = r_wr_en;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wr_en ? w_pattern : '0;

endmodule
